// File: rtl/approx_adder_pipe_if.sv
// Operand/result stream and error-monitor statistics bundle for approx_adder_pipe.
// The adder uses the slave view; the operand source / result sink uses master.
interface approx_adder_pipe_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out_sum;
   logic [WIDTH:0]   out_err;
   logic             stat_clr;
   logic [31:0]      stat_samples;
   logic [15:0]      stat_viol;
   logic [WIDTH:0]   stat_max_err;
   logic             viol_flag;

   modport slave (
      input  in_valid, in_a, in_b, out_ready, stat_clr,
      output in_ready, out_valid, out_sum, out_err,
             stat_samples, stat_viol, stat_max_err, viol_flag
   );

   modport master (
      output in_valid, in_a, in_b, out_ready, stat_clr,
      input  in_ready, out_valid, out_sum, out_err,
             stat_samples, stat_viol, stat_max_err, viol_flag
   );
endinterface

// File: rtl/approx_adder_pipe.sv
// Two-stage valid/ready lower-part-OR approximate adder with an optional error
// monitor, built only when APPROX_ERR_MON_EN is defined.
module approx_adder_pipe #(
   parameter int WIDTH       = 4,
   parameter int APPROX_BITS = 2,
   parameter int ET          = 1
) (
   input  logic                clk,
   input  logic                rst,
   approx_adder_pipe_if.slave  bus
);
   localparam int K = APPROX_BITS;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_s2_valid;
   logic [WIDTH:0]   r_sum;
   logic             w_s2_load;
   logic             w_s1_load;
   logic [WIDTH:0]   w_approx;

   assign w_s2_load    = !r_s2_valid || bus.out_ready;
   assign w_s1_load    = !r_s1_valid || w_s2_load;
   assign bus.in_ready = w_s1_load;

   // Low K bits are OR-ed; their top AND feeds the exact upper adder as carry-in.
   generate
      if (K == 0) begin : g_exact
         assign w_approx = {1'b0, r_a} + {1'b0, r_b};
      end else if (K == WIDTH) begin : g_all_or
         assign w_approx = {r_a[K-1] & r_b[K-1], r_a | r_b};
      end else begin : g_split
         logic [WIDTH-K:0] w_hi;
         assign w_hi = {1'b0, r_a[WIDTH-1:K]} + {1'b0, r_b[WIDTH-1:K]}
                     + {{(WIDTH-K){1'b0}}, r_a[K-1] & r_b[K-1]};
         assign w_approx = {w_hi, r_a[K-1:0] | r_b[K-1:0]};
      end
   endgenerate

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_a <= bus.in_a;
            r_b <= bus.in_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_sum      <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) r_sum <= w_approx;
      end
   end

   assign bus.out_valid = r_s2_valid;
   assign bus.out_sum   = r_sum;

`ifdef APPROX_ERR_MON_EN
   localparam logic [WIDTH:0] ET_W = (WIDTH+1)'(ET);

   logic [WIDTH:0] w_exact;
   logic [WIDTH:0] w_err;
   logic [WIDTH:0] r_err;
   logic [WIDTH:0] r_max_err;
   logic [31:0]    r_samples;
   logic [15:0]    r_viol;
   logic           r_viol_flag;
   logic           w_out_xfer;

   // The carry-in into the upper part can push the result above the exact sum.
   assign w_exact    = {1'b0, r_a} + {1'b0, r_b};
   assign w_err      = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);
   assign w_out_xfer = r_s2_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_err <= '0;
      else if (w_s2_load && r_s1_valid) r_err <= w_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_samples   <= '0;
         r_viol      <= '0;
         r_max_err   <= '0;
         r_viol_flag <= 1'b0;
      end else if (bus.stat_clr) begin
         r_samples   <= '0;
         r_viol      <= '0;
         r_max_err   <= '0;
         r_viol_flag <= 1'b0;
      end else if (w_out_xfer) begin
         if (r_samples != '1) r_samples <= r_samples + 32'd1;
         if (r_err > ET_W) begin
            if (r_viol != '1) r_viol <= r_viol + 16'd1;
            r_viol_flag <= 1'b1;
         end
         if (r_err > r_max_err) r_max_err <= r_err;
      end
   end

   assign bus.out_err      = r_err;
   assign bus.stat_samples = r_samples;
   assign bus.stat_viol    = r_viol;
   assign bus.stat_max_err = r_max_err;
   assign bus.viol_flag    = r_viol_flag;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = bus.stat_clr | (ET > 0);

   assign bus.out_err      = '0;
   assign bus.stat_samples = '0;
   assign bus.stat_viol    = '0;
   assign bus.stat_max_err = '0;
   assign bus.viol_flag    = 1'b0;
`endif
endmodule

// File: doc/approx_adder_pipe.md
# approx_adder_pipe

Parametrised, pipelined approximate adder: unsigned WIDTH-bit operands, lower-part-OR approximation on the APPROX_BITS least-significant bits, exact upper part. It is the streaming successor of the generated combinational approximate adders. It adds valid/ready flow control and an optional run-time error monitor that checks each result against the exact sum and the error threshold ET. It sits between an operand source and a result sink in approximate-datapath evaluation builds.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..32.
- APPROX_BITS, 2: number of approximated low bits; legal range 0..WIDTH. A value of 0 gives an exact adder.
- ET, 1: error threshold; a result with absolute error > ET is a violation.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a, in_b  in  WIDTH  unsigned operands.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result this cycle.
- out_sum  out  WIDTH+1  approximate sum.
- out_err  out  WIDTH+1  absolute error of out_sum versus the exact sum.
- stat_clr  in  1  synchronous clear of the statistics.
- stat_samples  out  32  results delivered; saturates at 2^32-1.
- stat_viol  out  16  delivered results with out_err > ET; saturates at 2^16-1.
- stat_max_err  out  WIDTH+1  largest out_err delivered since the last clear.
- viol_flag  out  1  sticky flag; set on the first violation, cleared only by stat_clr or rst.

## Operation
- Approximation, with K = APPROX_BITS:
  - sum[K-1:0] = a[K-1:0] | b[K-1:0].
  - cin = a[K-1] & b[K-1], or 0 when K = 0.
  - sum[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K] + cin, computed at full width including the carry-out.
  - When K = WIDTH the upper part is only cin.
- Exact sum = a + b at WIDTH+1 bits. out_err = |exact - approx|, computed at WIDTH+1 bits.
- Pipeline stages:
  - S1 registers the operands.
  - S2 registers out_sum and out_err.
  - Each stage has a valid bit. There are no other states.
- Advance rules:
  - S2 loads when S2 is empty or out_ready = 1.
  - S1 loads when S1 is empty or S1 moves into S2.
  - in_ready = !s1_valid | s2_load. It depends combinationally on out_ready.
  - A transfer occurs when valid & ready are both high at a clock edge.
- Statistics update only on an output transfer (out_valid & out_ready):
  - samples increments.
  - viol increments if out_err > ET, and viol_flag is set.
  - max_err = max(max_err, out_err).
- stat_clr has priority over a same-cycle transfer. All statistics go to 0 and that transfer is not counted. The data path is unaffected.
- Counters saturate and never wrap.
- Reset while data is in flight drops it. Data and statistics registers all clear.

## Timing
- Reset values: in_ready 1 once rst is deasserted, because both stages are empty. out_valid 0, out_sum 0, out_err 0, all stat_* 0, viol_flag 0.
- Latency is 2 cycles from input transfer to out_valid. Throughput is 1 result per cycle while out_ready = 1.
- With out_ready = 0, two pairs are held (S1 and S2) and in_ready falls in the cycle after S1 fills.
- Statistics outputs reflect a transfer one cycle after it.
- out_sum and out_err stay stable while out_valid = 1 and out_ready = 0.

## Configuration
- APPROX_ERR_MON_EN:
  - Defined: the exact adder, the out_err datapath and all stat_* / viol_flag logic are built.
  - Undefined: out_err, stat_samples, stat_viol, stat_max_err and viol_flag are tied to 0, stat_clr is ignored, and no exact adder is instantiated. out_sum and the handshake are bit- and cycle-identical in both builds.

## Test plan
All scenarios use WIDTH=4, APPROX_BITS=2, ET=1, with APPROX_ERR_MON_EN defined unless noted.
- Reset: assert rst mid-stream -> out_valid=0, all stats 0; after release in_ready=1 and the first result appears 2 cycles after its input transfer.
- Directed sums, streamed back-to-back with out_ready=1:
  - (3,1) -> sum 3, err 1.
  - (3,3) -> 7, err 1.
  - (2,2) -> 6, err 2.
  - (15,15) -> 31, err 1.
  - Afterwards: stat_samples=4, stat_viol=1, stat_max_err=2, viol_flag=1.
- Backpressure: hold out_ready=0 and push 3 pairs -> only 2 accepted, in_ready=0, out_sum held. Release out_ready -> results in order, none lost or duplicated.
- stat_clr asserted in the same cycle as a transfer of (2,2) -> all stats 0 the next cycle and viol_flag stays 0.
- Saturation: preload or force stat_viol to 16'hFFFF, then deliver a violation -> it stays 16'hFFFF.
- Build without APPROX_ERR_MON_EN, same stream as the directed-sums scenario -> identical out_sum and timing, and all monitor outputs 0.
